// File: rtl/capture_pkg.sv
// Shared encodings for the camera frame capture controller.
package capture_pkg;

  localparam int FRAME_BYTES_DEF = 614400;  // 640x480 RGB565

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_CONT   = 2'b10;
  localparam logic [1:0] MODE_STOP2  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CAPT = 2'd2,
    ST_SWAP = 2'd3
  } cap_state_t;

  function automatic logic mode_run(input logic [1:0] m);
    return (m == MODE_SINGLE) || (m == MODE_CONT);
  endfunction

endpackage

// File: rtl/capture_frame_ctrl.sv
// Double-buffered frame capture: writes each frame into the back buffer and
// swaps front/back on a complete frame once the display releases rd_lock.
module capture_frame_ctrl
  import capture_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int AW          = 20
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic          cap_we,
  input  logic [AW-1:0] cap_addr,
  input  logic          cap_end,
  input  logic          rd_lock,
  output logic [1:0]    fb_we,
  output logic [AW-1:0] fb_addr,
  output logic          front_sel,
  output logic          frame_done,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic [1:0]    err
);

  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BYTES);

  cap_state_t    state;
  logic          vsync_q;
  logic [CW-1:0] cnt;
  logic          run;
  cap_state_t    exit_st;

  assign run     = mode_run(mode);
  // Single vs continuous is only decided when leaving SWAP.
  assign exit_st = (mode == MODE_CONT) ? ST_ARM : ST_IDLE;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vsync_q    <= 1'b1;
      cnt        <= '0;
      fb_we      <= '0;
      fb_addr    <= '0;
      front_sel  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err        <= '0;
    end else begin
      vsync_q    <= vsync;
      fb_we      <= '0;
      frame_done <= 1'b0;
      if (!run) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state <= ST_ARM;
            err   <= '0;
          end
          ST_ARM: if (vsync_q && !vsync) begin
            state <= ST_CAPT;
            cnt   <= '0;
          end
          ST_CAPT: begin
            if (cap_we) begin
              if (cnt < FULL) begin
                fb_we   <= front_sel ? 2'b01 : 2'b10;
                fb_addr <= cap_addr;
                cnt     <= cnt + 1'b1;
              end else begin
                err[0] <= 1'b1;
              end
            end
            if (cap_end) state <= ST_SWAP;
          end
          ST_SWAP: begin
            if (cnt != FULL) begin
              err[1] <= 1'b1;
              state  <= exit_st;
            end else if (!rd_lock) begin
              front_sel  <= ~front_sel;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
              state      <= exit_st;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/capture_frame_ctrl.md
CAPTURE_FRAME_CTRL -- requirements
Module: capture_frame_ctrl

Interface
REQ-001 SHALL have parameter: FRAME_BYTES, 614400, bytes per complete frame (640x480 RGB565).
REQ-002 SHALL have parameter: AW, 20, frame-buffer address width.
REQ-003 SHALL have port: pclk  in  1  camera pixel clock; all logic on rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: vsync  in  1  camera vsync, pclk domain, high = vertical blanking.
REQ-006 SHALL have port: mode  in  2  00 stop, 01 single-shot, 10 continuous, 11 treated as 00.
REQ-007 SHALL have port: start  in  1  one-cycle arm pulse.
REQ-008 SHALL have port: cap_we  in  1  byte write strobe from capture datapath.
REQ-009 SHALL have port: cap_addr  in  AW  byte address from capture datapath.
REQ-010 SHALL have port: cap_end  in  1  end-of-frame indication from capture datapath.
REQ-011 SHALL have port: rd_lock  in  1  display is mid-scan of front buffer; swap forbidden.
REQ-012 SHALL have port: fb_we  out  2  per-buffer write enable, bit n = buffer n.
REQ-013 SHALL have port: fb_addr  out  AW  registered copy of cap_addr.
REQ-014 SHALL have port: front_sel  out  1  buffer the display reads; back buffer = ~front_sel.
REQ-015 SHALL have port: frame_done  out  1  one-cycle pulse per committed swap.
REQ-016 SHALL have port: busy  out  1  high in any state except IDLE.
REQ-017 SHALL have port: frame_cnt  out  16  committed frames, wraps 0xFFFF->0.
REQ-018 SHALL have port: err  out  2  sticky; bit0 overflow (>FRAME_BYTES), bit1 short frame.

Function
REQ-019 SHALL implement states IDLE, ARM, CAPT, SWAP.
REQ-020 IDLE: start=1 with mode 01/10 -> ARM; start with mode 00/11 ignored.
REQ-021 ARM: vsync falling edge (1->0, detected with one registered vsync) -> CAPT, byte counter cleared to 0.
REQ-022 CAPT: each cap_we=1 with counter<FRAME_BYTES -> fb_we[~front_sel]=1 next cycle, fb_addr=cap_addr, counter+1.
REQ-023 CAPT: cap_we=1 with counter==FRAME_BYTES -> write suppressed, err[0] set.
REQ-024 CAPT: cap_end=1 -> SWAP; a cap_we in the same cycle is still written (REQ-022/023 apply).
REQ-025 SWAP: counter!=FRAME_BYTES -> err[1] set, no swap, no frame_done, next ARM (continuous) or IDLE (single).
REQ-026 SWAP: counter==FRAME_BYTES and rd_lock=0 -> front_sel toggles, frame_done=1 one cycle, frame_cnt+1, next ARM (continuous) or IDLE (single).
REQ-027 SWAP: full frame and rd_lock=1 -> hold in SWAP; cap_we ignored; swap on first cycle rd_lock=0.
REQ-028 fb_we SHALL be 0 outside CAPT; latency cap_we->fb_we exactly 1 cycle; never both bits high.
REQ-029 mode=00/11 in any state -> IDLE next cycle, no swap, no frame_done, front_sel unchanged; pending writes dropped.
REQ-030 mode change 01<->10 mid-frame SHALL take effect at SWAP exit only.
REQ-031 err bits SHALL clear only on start pulse accepted in IDLE, or reset.

Reset
REQ-032 rst_n=0 SHALL force state IDLE, fb_we=0, fb_addr=0, front_sel=0, frame_done=0, busy=0, frame_cnt=0, err=0, counter=0, vsync register=1.
REQ-033 Reset mid-frame SHALL abandon the frame with no swap after release.

Structure
REQ-034 State encoding, mode codes and FRAME_BYTES default SHALL live in shared package capture_pkg.
REQ-035 No sub-module; vsync edge detect and byte counter inline; counter width ceil(log2(FRAME_BYTES+1)).

Verification (FRAME_BYTES=8)
REQ-036 mode=10, start, vsync 1->0, 8 cap_we, cap_end -> fb_we=2'b10 x8, front_sel 0->1, frame_done once, frame_cnt=1.
REQ-037 Same with rd_lock=1 for 20 cycles at cap_end -> state SWAP held, swap/frame_done on cycle after rd_lock falls.
REQ-038 10 cap_we in one frame -> 8 writes, err=2'b01, swap still committed.
REQ-039 5 cap_we then cap_end -> err=2'b10, front_sel unchanged, frame_cnt unchanged, back to ARM.
REQ-040 mode=01 -> one swap then IDLE, busy=0; mode 10 -> 00 mid-CAPT -> IDLE next cycle, fb_we=0, no frame_done.
REQ-041 rst_n pulsed mid-CAPT -> all outputs at REQ-032 values, no swap after release.
